// File: rtl/ram_arbiter_2p_pkg.sv
// Shared widths and requester ids for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/ram_arbiter_2p_rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational, last winner is registered.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_t last_gnt_q, last_gnt_d;

  // A wins a conflict only when B had the previous grant.
  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      if (req[0] && (!req[1] || last_gnt_q == REQ_B)) gnt[0] = 1'b1;
      else if (req[1])                                gnt[1] = 1'b1;
    end
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt[0])      last_gnt_d = REQ_A;
    else if (gnt[1]) last_gnt_d = REQ_B;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_gnt_q <= REQ_B;
    else        last_gnt_q <= last_gnt_d;
  end

endmodule

// File: rtl/ram_arbiter_2p.sv
// Shares one single-port RAM between requesters A and B and routes read data back.
module ram_arbiter_2p
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  logic [1:0] gnt;
  logic       rd_pend_q, rd_pend_d;
  req_id_t    rd_owner_q, rd_owner_d;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({b_req, a_req}),
    .gnt   (gnt)
  );

  assign a_gnt = gnt[0];
  assign b_gnt = gnt[1];

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt[0]) begin
      ram_we   = a_we;
      ram_addr = a_addr;
      ram_din  = a_wdata;
    end else if (gnt[1]) begin
      ram_we   = b_we;
      ram_addr = b_addr;
      ram_din  = b_wdata;
    end
  end

  // Owner only changes on a granted read so it stays valid for the return cycle.
  always_comb begin
    rd_pend_d  = (|gnt) && !ram_we;
    rd_owner_d = rd_owner_q;
    if (rd_pend_d) rd_owner_d = gnt[1] ? REQ_B : REQ_A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= REQ_A;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign a_rvalid = rd_pend_q && (rd_owner_q == REQ_A);
  assign b_rvalid = rd_pend_q && (rd_owner_q == REQ_B);
  assign a_rdata  = ram_dout;
  assign b_rdata  = ram_dout;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Bench for ram_arbiter_2p: behavioural RAM, round-robin reference model, directed + random scenarios.
module tb_ram_arbiter_2p;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [7:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din, ram_dout;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_arbiter_2p dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Physical RAM: write has priority, read data registered.
  logic [15:0] mem [256] = '{default: 16'h0000};
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else        ram_dout      <= mem[ram_addr];
  end

  // Reference model: memory image, last winner (0=A,1=B), pending read return.
  logic [15:0] ref_mem [256] = '{default: 16'h0000};
  logic        m_last = 1'b1;
  logic        m_pend = 1'b0;
  logic        m_owner = 1'b0;
  logic [15:0] m_data = '0;
  logic [1:0]  m_g = '0;

  function automatic logic [1:0] exp_gnt(input logic ra, input logic rb, input logic last);
    if (ra && rb) return last ? 2'b01 : 2'b10;
    return {rb, ra};
  endfunction

  task automatic adv();
    logic [1:0] g;
    g = rst_n ? exp_gnt(a_req, b_req, m_last) : 2'b00;
    @(posedge clk);
    if (!rst_n) begin
      m_last = 1'b1; m_pend = 1'b0; m_g = 2'b00;
    end else begin
      m_g = g; m_pend = 1'b0;
      if (g[0]) begin
        m_last = 1'b0;
        if (a_we) ref_mem[a_addr] = a_wdata;
        else begin m_pend = 1'b1; m_owner = 1'b0; m_data = ref_mem[a_addr]; end
      end else if (g[1]) begin
        m_last = 1'b1;
        if (b_we) ref_mem[b_addr] = b_wdata;
        else begin m_pend = 1'b1; m_owner = 1'b1; m_data = ref_mem[b_addr]; end
      end
    end
    #1;
  endtask

  task automatic drive_a(input logic r, input logic w, input logic [7:0] ad, input logic [15:0] d);
    a_req = r; a_we = w; a_addr = ad; a_wdata = d;
  endtask

  task automatic drive_b(input logic r, input logic w, input logic [7:0] ad, input logic [15:0] d);
    b_req = r; b_we = w; b_addr = ad; b_wdata = d;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    m_last = 1'b1; m_pend = 1'b0;
    adv(); adv();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_a(1'b1, 1'b0, 8'h01, 16'h0);
    drive_b(1'b1, 1'b0, 8'h02, 16'h0);
    @(negedge clk);
    n_assert++;
    if ({a_gnt, b_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got %b want 00", {a_gnt, b_gnt}); end
    n_assert++;
    if ({a_rvalid, b_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got %b want 00", {a_rvalid, b_rvalid}); end
    adv(); adv();
    drive_a(1'b0, 1'b0, 8'h0, 16'h0);
    drive_b(1'b0, 1'b0, 8'h0, 16'h0);
    rst_n = 1'b1;
    adv();
  endtask

  task automatic test_write_read();
    drive_a(1'b1, 1'b1, 8'h10, 16'hBEEF);
    @(negedge clk);
    n_assert++;
    if ({a_gnt, b_gnt, ram_we, ram_addr, ram_din} !== {2'b10, 1'b1, 8'h10, 16'hBEEF}) begin
      n_fail++; $display("FAIL wr_port got gnt=%b%b we=%b addr=%h din=%h want 10 1 10 beef",
                         a_gnt, b_gnt, ram_we, ram_addr, ram_din);
    end
    n_assert++;
    if ({a_rvalid, b_rvalid} !== 2'b00) begin n_fail++; $display("FAIL wr_rvalid got %b want 00", {a_rvalid, b_rvalid}); end
    adv();
    drive_a(1'b0, 1'b0, 8'h0, 16'h0);
    drive_b(1'b1, 1'b0, 8'h10, 16'h0);
    @(negedge clk);
    n_assert++;
    if ({a_gnt, b_gnt} !== 2'b01) begin n_fail++; $display("FAIL rd_gnt got %b want 01", {a_gnt, b_gnt}); end
    n_assert++;
    if ({a_rvalid, b_rvalid} !== 2'b00) begin n_fail++; $display("FAIL wr_no_resp got %b want 00", {a_rvalid, b_rvalid}); end
    adv();
    drive_b(1'b0, 1'b0, 8'h0, 16'h0);
    @(negedge clk);
    n_assert++;
    if ({a_rvalid, b_rvalid, b_rdata} !== {2'b01, 16'hBEEF}) begin
      n_fail++; $display("FAIL rd_return got rv=%b%b data=%h want 01 beef", a_rvalid, b_rvalid, b_rdata);
    end
    adv();
  endtask

  task automatic test_fairness();
    logic [1:0] want [6] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive_a(1'b1, 1'b0, 8'(i), 16'h0);
      drive_b(1'b1, 1'b0, 8'(i + 8), 16'h0);
      @(negedge clk);
      n_assert++;
      if ({a_gnt, b_gnt} !== want[i]) begin
        n_fail++; $display("FAIL fair_%0d got %b%b want %b", i, a_gnt, b_gnt, want[i]);
      end
      adv();
    end
    drive_a(1'b0, 1'b0, 8'h0, 16'h0);
    drive_b(1'b0, 1'b0, 8'h0, 16'h0);
    adv();
  endtask

  task automatic test_back_to_back();
    drive_b(1'b1, 1'b1, 8'hFF, 16'h00AA); adv();
    drive_b(1'b0, 1'b0, 8'h00, 16'h0);
    drive_a(1'b1, 1'b1, 8'h20, 16'h1234); adv();
    drive_a(1'b1, 1'b0, 8'h20, 16'h0);    adv();
    drive_a(1'b0, 1'b0, 8'h00, 16'h0);
    drive_b(1'b1, 1'b0, 8'hFF, 16'h0);
    @(negedge clk);
    n_assert++;
    if ({b_gnt, a_rvalid, b_rvalid, a_rdata} !== {1'b1, 2'b10, 16'h1234}) begin
      n_fail++; $display("FAIL b2b_a got gnt_b=%b rv=%b%b data=%h want 1 10 1234", b_gnt, a_rvalid, b_rvalid, a_rdata);
    end
    adv();
    drive_b(1'b0, 1'b0, 8'h00, 16'h0);
    @(negedge clk);
    n_assert++;
    if ({a_rvalid, b_rvalid, b_rdata} !== {2'b01, 16'h00AA}) begin
      n_fail++; $display("FAIL b2b_b got rv=%b%b data=%h want 01 00aa", a_rvalid, b_rvalid, b_rdata);
    end
    adv();
  endtask

  task automatic test_reset_mid();
    drive_a(1'b1, 1'b0, 8'h20, 16'h0); adv();
    drive_a(1'b0, 1'b0, 8'h00, 16'h0);
    rst_n = 1'b0;
    m_pend = 1'b0; m_last = 1'b1;
    @(negedge clk);
    n_assert++;
    if ({a_rvalid, b_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rstmid_rvalid got %b want 00", {a_rvalid, b_rvalid}); end
    adv();
    rst_n = 1'b1;
    @(negedge clk);
    n_assert++;
    if ({a_rvalid, b_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rstmid_after got %b want 00", {a_rvalid, b_rvalid}); end
    adv();
    drive_a(1'b1, 1'b0, 8'h01, 16'h0);
    drive_b(1'b1, 1'b0, 8'h02, 16'h0);
    @(negedge clk);
    n_assert++;
    if ({a_gnt, b_gnt} !== 2'b10) begin n_fail++; $display("FAIL rstmid_first got %b want 10", {a_gnt, b_gnt}); end
    adv();
    drive_a(1'b0, 1'b0, 8'h00, 16'h0);
    drive_b(1'b0, 1'b0, 8'h00, 16'h0);
    adv();
  endtask

  task automatic test_idle();
    drive_a(1'b1, 1'b1, 8'h33, 16'h5A5A); adv();
    drive_a(1'b0, 1'b0, 8'h00, 16'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_assert++;
      if ({a_gnt, b_gnt, ram_we, ram_addr, ram_din, a_rvalid, b_rvalid} !== 29'h0) begin
        n_fail++; $display("FAIL idle_%0d got gnt=%b%b we=%b addr=%h din=%h rv=%b%b want all 0",
                           i, a_gnt, b_gnt, ram_we, ram_addr, ram_din, a_rvalid, b_rvalid);
      end
      adv();
    end
    drive_a(1'b1, 1'b0, 8'h01, 16'h0);
    drive_b(1'b1, 1'b0, 8'h02, 16'h0);
    @(negedge clk);
    n_assert++;
    if ({a_gnt, b_gnt} !== 2'b01) begin n_fail++; $display("FAIL idle_winner got %b want 01", {a_gnt, b_gnt}); end
    adv();
    drive_a(1'b0, 1'b0, 8'h00, 16'h0);
    drive_b(1'b0, 1'b0, 8'h00, 16'h0);
    adv();
  endtask

  task automatic test_random();
    logic [1:0]  g;
    logic        ewe;
    logic [7:0]  ead;
    logic [15:0] ed;
    for (int i = 0; i < 400; i++) begin
      // An ungranted request must stay exactly as it was.
      if (!a_req || m_g[0])
        drive_a($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom));
      if (!b_req || m_g[1])
        drive_b($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom));
      g   = exp_gnt(a_req, b_req, m_last);
      ewe = g[0] ? a_we    : g[1] ? b_we    : 1'b0;
      ead = g[0] ? a_addr  : g[1] ? b_addr  : 8'h00;
      ed  = g[0] ? a_wdata : g[1] ? b_wdata : 16'h0;
      @(negedge clk);
      n_assert++;
      if ({a_gnt, b_gnt} !== {g[0], g[1]} || {ram_we, ram_addr, ram_din} !== {ewe, ead, ed}) begin
        n_fail++; $display("FAIL rnd_port_%0d got gnt=%b%b we=%b addr=%h din=%h want %b%b %b %h %h",
                           i, a_gnt, b_gnt, ram_we, ram_addr, ram_din, g[0], g[1], ewe, ead, ed);
      end
      n_assert++;
      if ({a_rvalid, b_rvalid} !== {m_pend && !m_owner, m_pend && m_owner} ||
          (a_rvalid && a_rdata !== m_data) || (b_rvalid && b_rdata !== m_data)) begin
        n_fail++; $display("FAIL rnd_ret_%0d got rv=%b%b a=%h b=%h want rv=%b%b data=%h",
                           i, a_rvalid, b_rvalid, a_rdata, b_rdata, m_pend && !m_owner, m_pend && m_owner, m_data);
      end
      adv();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_fairness();
    test_back_to_back();
    test_reset_mid();
    test_idle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
